// File: rtl/wave_param_meter.sv
// wave_param_meter: gated waveform meter. A hysteresis comparator turns the
// sample stream into edges. Each gate window reports the edge count, the
// first-to-last edge span and the sample max/min/peak-to-peak. There are no
// dividers; software derives frequency from edge_cnt and span_cnt.
module wave_param_meter #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 32,
  parameter int EDGE_W      = 20,
  parameter int GATE_CYCLES = 50_000_000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ad_valid,
  input  logic [DATA_W-1:0] ad_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] trig_hyst,
  input  logic              edge_sel,
  output logic              meas_done,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              edge_ovf,
  output logic [CNT_W-1:0]  span_cnt,
  output logic [DATA_W-1:0] ad_max,
  output logic [DATA_W-1:0] ad_min,
  output logic [DATA_W-1:0] ad_vpp,
  output logic              no_data
);

  typedef enum logic [1:0] {
    CMP_UNK  = 2'd0,
    CMP_LOW  = 2'd1,
    CMP_HIGH = 2'd2
  } cmp_t;

  localparam logic [CNT_W-1:0]  GATE_LAST  = CNT_W'(GATE_CYCLES - 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX   = {EDGE_W{1'b1}};
  localparam logic [EDGE_W-1:0] EDGE_ZERO  = {EDGE_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ONES  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

  logic [CNT_W-1:0]  gate_cnt_r;
  logic              gate_last_s;
  cmp_t              cmp_r;
  cmp_t              cmp_nxt_s;
  logic              edge_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W:0]   dif_s;
  logic [DATA_W-1:0] hi_s;
  logic [DATA_W-1:0] lo_s;

  logic [EDGE_W-1:0] edge_acc_r, edge_nxt_s;
  logic              ovf_acc_r, ovf_nxt_s;
  logic [CNT_W-1:0]  first_ts_r, first_nxt_s;
  logic [CNT_W-1:0]  last_ts_r, last_nxt_s;
  logic [DATA_W-1:0] max_acc_r, max_nxt_s;
  logic [DATA_W-1:0] min_acc_r, min_nxt_s;
  logic              seen_r, seen_nxt_s;

  assign gate_last_s = (gate_cnt_r == GATE_LAST);

  // Thresholds in DATA_W+1 bits, clamped to the sample range.
  always_comb begin
    sum_s = {1'b0, trig_level} + {1'b0, trig_hyst};
    dif_s = {1'b0, trig_level} - {1'b0, trig_hyst};
    if (sum_s[DATA_W]) begin
      hi_s = DATA_ONES;
    end else begin
      hi_s = sum_s[DATA_W-1:0];
    end
    if (dif_s[DATA_W]) begin
      lo_s = DATA_ZERO;
    end else begin
      lo_s = dif_s[DATA_W-1:0];
    end
  end

  // Comparator next state (HIGH checked first so it wins on overlap) and edge detect.
  always_comb begin
    cmp_nxt_s = cmp_r;
    if (ad_valid) begin
      if (ad_data >= hi_s) begin
        cmp_nxt_s = CMP_HIGH;
      end else if (ad_data <= lo_s) begin
        cmp_nxt_s = CMP_LOW;
      end else begin
        cmp_nxt_s = cmp_r;
      end
    end else begin
      cmp_nxt_s = cmp_r;
    end
    if (edge_sel) begin
      edge_s = (cmp_r == CMP_HIGH) && (cmp_nxt_s == CMP_LOW);
    end else begin
      edge_s = (cmp_r == CMP_LOW) && (cmp_nxt_s == CMP_HIGH);
    end
  end

  // Accumulator values including the current cycle's sample and edge.
  always_comb begin
    edge_nxt_s  = edge_acc_r;
    ovf_nxt_s   = ovf_acc_r;
    first_nxt_s = first_ts_r;
    last_nxt_s  = last_ts_r;
    max_nxt_s   = max_acc_r;
    min_nxt_s   = min_acc_r;
    seen_nxt_s  = seen_r;
    if (edge_s) begin
      if (edge_acc_r == EDGE_MAX) begin
        ovf_nxt_s = 1'b1;
      end else begin
        edge_nxt_s = edge_acc_r + EDGE_W'(1'b1);
      end
      if (edge_acc_r == EDGE_ZERO) begin
        first_nxt_s = gate_cnt_r;
      end else begin
        first_nxt_s = first_ts_r;
      end
      last_nxt_s = gate_cnt_r;
    end else begin
      last_nxt_s = last_ts_r;
    end
    if (ad_valid) begin
      seen_nxt_s = 1'b1;
      if (ad_data > max_acc_r) begin
        max_nxt_s = ad_data;
      end else begin
        max_nxt_s = max_acc_r;
      end
      if (ad_data < min_acc_r) begin
        min_nxt_s = ad_data;
      end else begin
        min_nxt_s = min_acc_r;
      end
    end else begin
      seen_nxt_s = seen_r;
    end
  end

  // Free-running gate counter and persistent comparator state.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      gate_cnt_r <= {CNT_W{1'b0}};
      cmp_r      <= CMP_UNK;
    end else begin
      if (gate_last_s) begin
        gate_cnt_r <= {CNT_W{1'b0}};
      end else begin
        gate_cnt_r <= gate_cnt_r + CNT_W'(1'b1);
      end
      cmp_r <= cmp_nxt_s;
    end
  end

  // Window accumulators; cleared after the closing cycle has been folded in.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst || gate_last_s) begin
      edge_acc_r <= EDGE_ZERO;
      ovf_acc_r  <= 1'b0;
      first_ts_r <= {CNT_W{1'b0}};
      last_ts_r  <= {CNT_W{1'b0}};
      max_acc_r  <= DATA_ZERO;
      min_acc_r  <= DATA_ONES;
      seen_r     <= 1'b0;
    end else begin
      edge_acc_r <= edge_nxt_s;
      ovf_acc_r  <= ovf_nxt_s;
      first_ts_r <= first_nxt_s;
      last_ts_r  <= last_nxt_s;
      max_acc_r  <= max_nxt_s;
      min_acc_r  <= min_nxt_s;
      seen_r     <= seen_nxt_s;
    end
  end

  // Result registers, loaded once per window and held otherwise.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      meas_done <= 1'b0;
      edge_cnt  <= EDGE_ZERO;
      edge_ovf  <= 1'b0;
      span_cnt  <= {CNT_W{1'b0}};
      ad_max    <= DATA_ZERO;
      ad_min    <= DATA_ZERO;
      ad_vpp    <= DATA_ZERO;
      no_data   <= 1'b0;
    end else begin
      meas_done <= gate_last_s;
      if (gate_last_s) begin
        edge_cnt <= edge_nxt_s;
        edge_ovf <= ovf_nxt_s;
        if (edge_nxt_s >= EDGE_W'(2'd2)) begin
          span_cnt <= last_nxt_s - first_nxt_s;
        end else begin
          span_cnt <= {CNT_W{1'b0}};
        end
        if (seen_nxt_s) begin
          ad_max  <= max_nxt_s;
          ad_min  <= min_nxt_s;
          ad_vpp  <= max_nxt_s - min_nxt_s;
          no_data <= 1'b0;
        end else begin
          ad_max  <= DATA_ZERO;
          ad_min  <= DATA_ZERO;
          ad_vpp  <= DATA_ZERO;
          no_data <= 1'b1;
        end
      end else begin
        edge_cnt <= edge_cnt;
      end
    end
  end

endmodule

// File: doc/wave_param_meter.md
# wave_param_meter

Parametrised single-clock waveform parameter meter for the oscilloscope datapath. It consumes a strobed ADC sample stream and repeatedly measures over fixed gate windows. It converts the samples to edges with a hysteresis comparator and reports, per window, the edge count, the edge time span, and max/min/peak-to-peak. Software derives frequency as CLK_FS·(edge_cnt−1)/span_cnt, so the block contains no dividers.

## Interface
Parameters:
- DATA_W, 8: sample width.
- CNT_W, 32: gate counter and span width.
- EDGE_W, 20: edge counter width.
- GATE_CYCLES, 50_000_000: window length in sys_clk cycles. Range is 2 ≤ GATE_CYCLES < 2^CNT_W.

Ports:
- sys_clk  in  1  sole clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- ad_valid  in  1  sample strobe. ad_data is used only when high.
- ad_data  in  DATA_W  sample, unsigned.
- trig_level  in  DATA_W  comparator centre.
- trig_hyst  in  DATA_W  hysteresis half-width.
- edge_sel  in  1  0 = count rising edges, 1 = count falling edges.
- meas_done  out  1  one-cycle pulse when the result outputs update.
- edge_cnt  out  EDGE_W  edges in the last window, saturating.
- edge_ovf  out  1  edge counter saturated in the last window.
- span_cnt  out  CNT_W  cycles from the first to the last edge. 0 if edge_cnt < 2.
- ad_max  out  DATA_W  maximum valid sample in the last window.
- ad_min  out  DATA_W  minimum valid sample in the last window.
- ad_vpp  out  DATA_W  ad_max − ad_min.
- no_data  out  1  no valid sample in the last window.

## Operation
- **Gate counter:** gate_cnt runs 0…GATE_CYCLES−1, then wraps to 0. It runs continuously from reset release.
- **Thresholds:** computed combinationally in DATA_W+1 bits and clamped.
  - hi = min(trig_level + trig_hyst, 2^DATA_W − 1).
  - lo = max(trig_level − trig_hyst, 0).
- **Comparator state:** cmp ∈ {UNK, LOW, HIGH}. It updates only on valid samples.
  - sample ≥ hi → HIGH.
  - sample ≤ lo → LOW.
  - Otherwise cmp holds.
  - If hi ≤ lo conditions overlap (trig_hyst = 0 and sample = trig_level), HIGH wins.
- **Edge events:**
  - Rising edge: LOW→HIGH, counted when edge_sel = 0.
  - Falling edge: HIGH→LOW, counted when edge_sel = 1.
  - The UNK→any transition is never an edge.
  - cmp persists across windows. Only reset returns it to UNK.
- **Per-edge accumulation:**
  - edge_acc increments, saturating at 2^EDGE_W − 1.
  - An edge arriving while edge_acc is already saturated sets ovf_acc.
  - The first edge in the window stores first_ts = gate_cnt.
  - Every edge stores last_ts = gate_cnt.
- **Per-sample accumulation:** max_acc and min_acc update on every valid sample. The seen flag is set by any valid sample.
- **Window close:** on the cycle with gate_cnt = GATE_CYCLES−1, that cycle's sample and edge are included. On the next edge of sys_clk:
  - Outputs are loaded from the accumulators.
  - span_cnt = last_ts − first_ts, or 0 if the edge count < 2.
  - If seen = 0: ad_max = ad_min = ad_vpp = 0 and no_data = 1.
  - meas_done = 1 for that one cycle.
  - Accumulators clear: edge_acc = 0, max_acc = 0, min_acc = all ones, seen = 0, ovf_acc = 0.
- **Input changes:** trig_level, trig_hyst and edge_sel take effect on the next valid sample, mid-window included. No resynchronisation is done; callers change them between windows.
- **Outputs between updates:** all result outputs hold between meas_done pulses.

## Timing
- **Reset state:** every output is 0, cmp = UNK, gate_cnt = 0, and accumulators are cleared.
- **First result:** the first meas_done occurs GATE_CYCLES cycles after the first sys_clk edge with rst low. After that, meas_done repeats exactly every GATE_CYCLES cycles.
- **Sample-to-result latency:** a sample on the last gate cycle is reflected in outputs 1 cycle later.
- **Edge timestamp:** the gate_cnt of the cycle in which the edge-producing sample is valid.
- **Reset mid-window:** the partial window is discarded, outputs return to 0, and the gate restarts at 0.
- **Throughput:** a valid sample every cycle is supported. ad_valid may have any duty cycle.

## Test plan
- **Square wave, rising:** GATE_CYCLES=100, ad_valid=1 always, square 0x20/0xE0 with period 10 (rising on cycles 5, 15, …), trig 0x80/hyst 0x10, edge_sel=0. Required: from the second window, edge_cnt=10, span_cnt=90, ad_max=0xE0, ad_min=0x20, ad_vpp=0xC0, edge_ovf=0, no_data=0.
- **Hysteresis rejection:** samples alternating 0x78/0x88 each cycle, hyst 0x10. Required: edge_cnt=0, span_cnt=0, ad_vpp=0x10.
- **No samples:** ad_valid=0 for a whole window. Required: no_data=1, ad_max=ad_min=ad_vpp=0, edge_cnt=0, and meas_done still pulses on schedule.
- **Saturation:** EDGE_W=4, 20 edges in a window. Required: edge_cnt=15, edge_ovf=1. The next clean window reports edge_ovf=0.
- **Falling edges with clamped hi:** edge_sel=1, trig 0xF8/hyst 0x10 (hi clamps to 0xFF, lo=0xE8), wave 0x00/0xFF. Required: falling edges are counted correctly, and a wave peaking at 0xFE yields edge_cnt=0.
- **Reset mid-window:** assert rst at gate_cnt=40. Required: outputs go to 0 immediately, and the next meas_done comes exactly 100 cycles after reset release. A first sample of 0xE0 after reset produces no edge (UNK).
